// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - UART byte-stream framer decoding 11-byte write frames into a valid/ready write request
//
// Ports:
//   i_Clock         clock, same domain as the UART receiver
//   rst_ni          synchronous active-low reset
//   i_Rx_DV         one-cycle byte-valid strobe
//   i_Rx_Byte       received byte, sampled when i_Rx_DV=1
//   i_Timeout_Clks  inter-byte timeout in clocks (0 disables)
//   o_Wr_Valid      write request valid
//   i_Wr_Ready      write request accepted
//   o_Wr_Addr       write address
//   o_Wr_Data       write data
//   o_Frame_Err     one-cycle error pulse
//   o_Err_Count     saturating error count
//   o_Busy          high whenever the framer is not hunting for sync
module uart_cmd_decoder #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] CMD_WRITE = 8'h57
) (
    input  logic        i_Clock,
    input  logic        rst_ni,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    input  logic [23:0] i_Timeout_Clks,
    output logic        o_Wr_Valid,
    input  logic        i_Wr_Ready,
    output logic [31:0] o_Wr_Addr,
    output logic [31:0] o_Wr_Data,
    output logic        o_Frame_Err,
    output logic [7:0]  o_Err_Count,
    output logic        o_Busy
);

    localparam logic [2:0] ST_HUNT  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_CSUM  = 3'd4;
    localparam logic [2:0] ST_ISSUE = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  chk_q, chk_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] gap_q, gap_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;

    logic        in_frame;
    logic        timeout_hit;
    logic        error;

    // Timeout only applies while a frame is being assembled; a DV on the
    // same edge always takes priority over the gap check.
    assign in_frame    = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                         (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign timeout_hit = in_frame && !i_Rx_DV && (i_Timeout_Clks != 24'd0) &&
                         (gap_q == i_Timeout_Clks - 24'd1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        chk_d   = chk_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        error   = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == CMD_WRITE) begin
                        state_d = ST_ADDR;
                        chk_d   = i_Rx_Byte;
                        idx_d   = 2'd0;
                    end else begin
                        error   = 1'b1;
                        state_d = ST_HUNT;
                    end
                end
            end
            ST_ADDR: begin
                if (i_Rx_DV) begin
                    addr_d[{idx_q, 3'b000} +: 8] = i_Rx_Byte;
                    chk_d = chk_q ^ i_Rx_Byte;
                    idx_d = idx_q + 2'd1;   // wraps to 0 after the 4th byte
                    if (idx_q == 2'd3) begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (i_Rx_DV) begin
                    data_d[{idx_q, 3'b000} +: 8] = i_Rx_Byte;
                    chk_d = chk_q ^ i_Rx_Byte;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == chk_q) begin
                        state_d = ST_ISSUE;
                        valid_d = 1'b1;
                    end else begin
                        error   = 1'b1;
                        state_d = ST_HUNT;
                    end
                end
            end
            ST_ISSUE: begin
                // Any byte arriving while the request is pending is dropped
                // and reported; the request itself is left untouched.
                if (i_Rx_DV) begin
                    error = 1'b1;
                end
                if (i_Wr_Ready) begin
                    valid_d = 1'b0;
                    state_d = ST_HUNT;
                end
            end
            default: begin
                state_d = ST_HUNT;
                valid_d = 1'b0;
            end
        endcase

        if (timeout_hit) begin
            error   = 1'b1;
            state_d = ST_HUNT;
        end

        if (in_frame && !timeout_hit && (state_d != ST_HUNT)) begin
            gap_d = i_Rx_DV ? 24'd0 : gap_q + 24'd1;
        end else begin
            gap_d = 24'd0;
        end

        err_d  = error;
        cnt_d  = (error && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
        busy_d = (state_d != ST_HUNT);
    end

    always_ff @(posedge i_Clock) begin
        if (!rst_ni) begin
            state_q <= ST_HUNT;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            chk_q   <= 8'd0;
            idx_q   <= 2'd0;
            gap_q   <= 24'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            chk_q   <= chk_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign o_Wr_Valid  = valid_q;
    assign o_Wr_Addr   = addr_q;
    assign o_Wr_Data   = data_q;
    assign o_Frame_Err = err_q;
    assign o_Err_Count = cnt_q;
    assign o_Busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - directed self-checking bench for uart_cmd_decoder
module tb_uart_cmd_decoder;

    logic        clk;
    logic        rst_n;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic [23:0] tmo;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        frame_err;
    logic [7:0]  err_count;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    uart_cmd_decoder dut (
        .i_Clock        (clk),
        .rst_ni         (rst_n),
        .i_Rx_DV        (rx_dv),
        .i_Rx_Byte      (rx_byte),
        .i_Timeout_Clks (tmo),
        .o_Wr_Valid     (wr_valid),
        .i_Wr_Ready     (wr_ready),
        .o_Wr_Addr      (wr_addr),
        .o_Wr_Data      (wr_data),
        .o_Frame_Err    (frame_err),
        .o_Err_Count    (err_count),
        .o_Busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change at the negedge; the posedge samples; on return we sit at
    // the following negedge, where outputs reflect that sampling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    logic [7:0] good [11];
    logic [7:0] badc [11];
    logic [31:0] outs;
    int         err_seen;

    task automatic send_frame(input logic [7:0] f [11]);
        for (int i = 0; i < 11; i++) send_byte(f[i]);
    endtask

    initial begin
        good = '{8'hA5, 8'h57, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h7D};
        badc = '{8'hA5, 8'h57, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h7C};

        rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; tmo = 24'd0; wr_ready = 1'b0;

        // Reset held with random traffic: everything must stay zero.
        for (int i = 0; i < 20; i++) begin
            rx_dv   = 1'($urandom_range(0, 1));
            rx_byte = (i % 3 == 0) ? 8'hA5 : 8'($urandom);
            @(negedge clk);
            outs = {30'd0, wr_valid, frame_err} | wr_addr | wr_data | {24'd0, err_count} | {31'd0, busy};
            check("reset_outputs", outs, 32'd0);
        end
        rx_dv = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Good frame with 5 cycles of backpressure.
        send_byte(8'hA5);
        check("busy_after_sync", {31'd0, busy}, 32'd1);
        for (int i = 1; i < 11; i++) send_byte(good[i]);
        check("good_valid", {31'd0, wr_valid}, 32'd1);
        check("good_addr", wr_addr, 32'h12345678);
        check("good_data", wr_data, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, wr_valid}, 32'd1);
            check("hold_addr", wr_addr, 32'h12345678);
            check("hold_data", wr_data, 32'hDEADBEEF);
        end
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        check("ack_valid_low", {31'd0, wr_valid}, 32'd0);
        check("ack_busy_low", {31'd0, busy}, 32'd0);
        check("ack_no_err", {24'd0, err_count}, 32'd0);

        // Bad checksum.
        send_frame(badc);
        check("badcsum_err", {31'd0, frame_err}, 32'd1);
        check("badcsum_cnt", {24'd0, err_count}, 32'd1);
        check("badcsum_valid", {31'd0, wr_valid}, 32'd0);
        @(negedge clk);
        check("badcsum_err_pulse", {31'd0, frame_err}, 32'd0);

        // Bad command byte.
        send_byte(8'hA5);
        send_byte(8'h52);
        check("badcmd_err", {31'd0, frame_err}, 32'd1);
        check("badcmd_cnt", {24'd0, err_count}, 32'd2);
        for (int i = 2; i < 11; i++) send_byte(good[i]);
        check("badcmd_tail_cnt", {24'd0, err_count}, 32'd2);
        check("badcmd_tail_busy", {31'd0, busy}, 32'd0);

        // Garbage before sync, then a good frame.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check("garbage_busy", {31'd0, busy}, 32'd0);
        send_frame(good);
        check("garbage_valid", {31'd0, wr_valid}, 32'd1);
        check("garbage_cnt", {24'd0, err_count}, 32'd2);
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        check("garbage_ack", {31'd0, wr_valid}, 32'd0);

        // Timeout of 100 clocks: error exactly at edge 100 after the last DV.
        tmo = 24'd100;
        send_byte(8'hA5);
        send_byte(8'h57);
        send_byte(8'h78);
        err_seen = 0;
        for (int i = 1; i < 100; i++) begin
            @(negedge clk);
            if (frame_err) err_seen++;
        end
        check("timeout_early", err_seen, 32'd0);
        check("timeout_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("timeout_err", {31'd0, frame_err}, 32'd1);
        check("timeout_cnt", {24'd0, err_count}, 32'd3);
        check("timeout_busy_after", {31'd0, busy}, 32'd0);
        send_frame(good);
        check("after_timeout_valid", {31'd0, wr_valid}, 32'd1);
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        check("after_timeout_ack", {31'd0, wr_valid}, 32'd0);

        // Timeout disabled: the frame waits indefinitely.
        tmo = 24'd0;
        send_byte(8'hA5);
        send_byte(8'h57);
        send_byte(8'h78);
        err_seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_err) err_seen++;
        end
        check("notimeout_err", err_seen, 32'd0);
        check("notimeout_busy", {31'd0, busy}, 32'd1);
        for (int i = 3; i < 11; i++) send_byte(good[i]);
        check("notimeout_valid", {31'd0, wr_valid}, 32'd1);

        // Overrun while the request is pending.
        send_byte(8'h11);
        check("overrun_err", {31'd0, frame_err}, 32'd1);
        check("overrun_cnt", {24'd0, err_count}, 32'd4);
        check("overrun_valid", {31'd0, wr_valid}, 32'd1);
        check("overrun_addr", wr_addr, 32'h12345678);
        check("overrun_data", wr_data, 32'hDEADBEEF);
        // Overrun on the handshake edge itself.
        wr_ready = 1'b1;
        send_byte(8'h22);
        wr_ready = 1'b0;
        check("overrun_ack_err", {31'd0, frame_err}, 32'd1);
        check("overrun_ack_cnt", {24'd0, err_count}, 32'd5);
        check("overrun_ack_valid", {31'd0, wr_valid}, 32'd0);
        check("overrun_ack_busy", {31'd0, busy}, 32'd0);

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) send_frame(badc);
        check("sat_cnt", {24'd0, err_count}, 32'd255);
        check("sat_err_pulse", {31'd0, frame_err}, 32'd1);

        // Reset mid-frame, then a good frame.
        for (int i = 0; i < 5; i++) send_byte(good[i]);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_cnt", {24'd0, err_count}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_err", {31'd0, frame_err}, 32'd0);
        send_frame(good);
        check("midreset_valid", {31'd0, wr_valid}, 32'd1);
        check("midreset_addr", wr_addr, 32'h12345678);
        check("midreset_data", wr_data, 32'hDEADBEEF);
        check("midreset_no_err", {24'd0, err_count}, 32'd0);
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        check("midreset_ack", {31'd0, wr_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Byte-stream framer that sits directly downstream of `uart_receiver`. It consumes the receiver's one-cycle byte strobes, hunts for a sync byte, and assembles a fixed 11-byte write frame. It checks the frame's command and XOR checksum, then presents a 32-bit address/data write request on a valid/ready handshake to the SoC load/debug bus master. Errors are flagged per frame and counted.

## Interface
Parameters:
- `SYNC_BYTE`, 8'hA5, frame start marker
- `CMD_WRITE`, 8'h57, only accepted command code

Ports:
- `i_Clock`  in  1  clock (same domain as `uart_receiver`)
- `rst_ni`  in  1  reset; synchronous, active-low
- `i_Rx_DV`  in  1  one-cycle byte-valid strobe from the receiver
- `i_Rx_Byte`  in  8  received byte; sampled only when `i_Rx_DV`=1
- `i_Timeout_Clks`  in  24  inter-byte timeout in clocks; 0 disables timeout
- `o_Wr_Valid`  out  1  write request valid
- `i_Wr_Ready`  in  1  write request accepted
- `o_Wr_Addr`  out  32  write address
- `o_Wr_Data`  out  32  write data
- `o_Frame_Err`  out  1  one-cycle error pulse
- `o_Err_Count`  out  8  saturating error count
- `o_Busy`  out  1  high when state != HUNT

## Operation
Frame byte order:
- b0 = SYNC_BYTE
- b1 = CMD_WRITE
- b2..b5 = address, LSB first
- b6..b9 = data, LSB first
- b10 = checksum = XOR of b1..b9

All outputs are registered. State changes and updates below happen only on edges that sample `i_Rx_DV`=1, except in ISSUE and on timeout.

States:
- **HUNT**: byte == SYNC_BYTE -> CMD. Any other byte is discarded silently.
- **CMD**: byte == CMD_WRITE -> ADDR, with chk = byte and idx = 0. Any other byte is an error -> HUNT.
- **ADDR**: addr[8*idx +: 8] = byte; chk ^= byte; idx++. After the 4th byte -> DATA with idx = 0.
- **DATA**: same as ADDR, filling data. After the 4th byte -> CSUM.
- **CSUM**: byte == chk -> ISSUE and set `o_Wr_Valid`. Otherwise error -> HUNT.
- **ISSUE**: hold `o_Wr_Valid`=1 until an edge with `i_Wr_Ready`=1, then clear valid -> HUNT.
  - Any DV in ISSUE is an overrun error. The byte is dropped and the state remains ISSUE.
  - A DV on the same edge as the handshake is also an overrun; the state goes to HUNT.

Errors:
- Each error sets `o_Frame_Err` high for exactly one cycle.
- Each error increments `o_Err_Count`, which saturates at 255 and never wraps.

Timeout (states CMD..CSUM only):
- Gap counter (24-bit) is cleared on every DV edge and incremented on every other edge.
- If gap == `i_Timeout_Clks`-1 on an edge with no DV, that edge is a timeout error -> HUNT.
- DV wins over timeout on the same edge.
- `i_Timeout_Clks`=0 disables the check.
- The gap counter is held at 0 in HUNT and ISSUE.

Output values:
- `o_Wr_Addr`/`o_Wr_Data` are stable whenever `o_Wr_Valid`=1.
- Outside ISSUE they may change as bytes are assembled.

Reset:
- Values: state=HUNT, `o_Wr_Valid`=0, `o_Wr_Addr`=0, `o_Wr_Data`=0, `o_Frame_Err`=0, `o_Err_Count`=0, `o_Busy`=0, chk/idx/gap=0.
- Reset mid-frame or mid-ISSUE discards everything with no error pulse.

## Timing
- `o_Wr_Valid` rises on the edge that samples the checksum DV, i.e. one cycle after the DV cycle.
- `o_Frame_Err` rises on the edge that samples the offending DV (or the timeout edge) and is low again after the next edge.
- `o_Err_Count` updates on the same edge as `o_Frame_Err`.
- Timeout: with the last DV sampled at edge 0, the error is taken at edge `i_Timeout_Clks`.
- The block accepts DV on consecutive cycles, with no minimum byte spacing.
- Handshake completes on any edge with valid & ready. Ready may be high before valid.

## Test plan
- **Reset**: drive `rst_ni`=0 with random DV traffic -> every output is 0 and `o_Busy`=0 for the whole reset period.
- **Good frame with backpressure**: send A5 57 78 56 34 12 EF BE AD DE 7D and hold `i_Wr_Ready`=0 for 5 cycles -> `o_Wr_Valid`=1 with `o_Wr_Addr`=0x12345678 and `o_Wr_Data`=0xDEADBEEF held constant. On ready, valid drops next cycle, `o_Busy`=0, and there is no error.
- **Bad checksum and bad command**:
  - Same frame with last byte 7C -> one `o_Frame_Err` pulse, `o_Err_Count`=1, no valid.
  - Frame A5 52 ... -> `o_Err_Count`=2.
- **Garbage before sync**: send 00 FF 5A, then the good frame -> frame accepted and `o_Err_Count` unchanged.
- **Timeout**: with `i_Timeout_Clks`=100, send A5 57 78, then silence -> error exactly 100 edges after the last DV. A following good frame is accepted.
  - Repeat with `i_Timeout_Clks`=0 -> no error, `o_Busy` stays 1.
- **Overrun, saturation, and mid-frame reset**:
  - A DV during ISSUE -> error pulse, request unchanged.
  - 300 bad-checksum frames -> `o_Err_Count`=255.
  - Reset after 5 bytes, then a good frame -> accepted.
